// File: rtl/pc_pkg.sv
// Shared definitions for the program sequencer: command encoding and strobe priority.
// Used by program_sequencer; the stack feature is selected there via PC_STACK_EN.
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD   = 3'd0,
        CMD_UP     = 3'd1,
        CMD_BRANCH = 3'd2,
        CMD_RET    = 3'd3,
        CMD_CALL   = 3'd4,
        CMD_JUMP   = 3'd5
    } cmd_e;

    // Strobes may overlap; the highest-priority one wins and the rest are dropped.
    function automatic cmd_e pick_cmd(input logic up, input logic jump, input logic branch,
                                      input logic call, input logic ret);
        cmd_e cmd;
        if (jump)        cmd = CMD_JUMP;
        else if (call)   cmd = CMD_CALL;
        else if (ret)    cmd = CMD_RET;
        else if (branch) cmd = CMD_BRANCH;
        else if (up)     cmd = CMD_UP;
        else             cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Push and pop are mutually exclusive (the caller arbitrates);
// a push when full or a pop when empty is ignored here and flagged by the caller.
module return_stack #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] top_ptr;

    assign full_o  = (ptr_q == FULL_PTR);
    assign empty_o = (ptr_q == '0);
    // ptr_q counts entries, so the top lives one slot below it.
    assign top_ptr = ptr_q - PTR_W'(1);
    assign top_o   = mem_q[top_ptr[IDX_W-1:0]];

    always_comb begin
        ptr_d = ptr_q;
        if (push_i && !full_o)      ptr_d = ptr_q + PTR_W'(1);
        else if (pop_i && !empty_o) ptr_d = ptr_q - PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[ptr_q[IDX_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction address generator: increment, jump, relative branch and optional call/return.
// Define PC_STACK_EN to build the return-address stack; otherwise call acts as jump and ret holds.
module program_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  up,
    input  logic                  jump,
    input  logic                  branch,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  fault
);

    cmd_e                  cmd;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign cmd     = pick_cmd(up, jump, branch, call, ret);
    assign address = addr_q;

`ifdef PC_STACK_EN
    logic                  fault_q, fault_d;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] st_top;
    logic                  st_full, st_empty;

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clock),
        .rst_n   (clear_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (addr_q + ADDR_WIDTH'(1)),
        .top_o   (st_top),
        .full_o  (st_full),
        .empty_o (st_empty)
    );

    assign stack_full  = st_full;
    assign stack_empty = st_empty;
    assign fault       = fault_q;

    // Same-width add gives the sign-extended, wrap-around branch for free.
    always_comb begin
        addr_d  = addr_q;
        fault_d = fault_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (cmd)
            CMD_JUMP:   addr_d = target;
            CMD_CALL: begin
                if (!st_full) begin
                    push   = 1'b1;
                    addr_d = target;
                end else begin
                    fault_d = 1'b1;
                end
            end
            CMD_RET: begin
                if (!st_empty) begin
                    pop    = 1'b1;
                    addr_d = st_top;
                end else begin
                    fault_d = 1'b1;
                end
            end
            CMD_BRANCH: addr_d = addr_q + offset;
            CMD_UP:     addr_d = addr_q + ADDR_WIDTH'(1);
            default:    addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            addr_q  <= ADDR_WIDTH'(RESET_ADDR);
            fault_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            fault_q <= fault_d;
        end
    end
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign fault       = 1'b0;

    always_comb begin
        addr_d = addr_q;
        case (cmd)
            CMD_JUMP, CMD_CALL: addr_d = target;
            CMD_BRANCH:         addr_d = addr_q + offset;
            CMD_UP:             addr_d = addr_q + ADDR_WIDTH'(1);
            default:            addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) addr_q <= ADDR_WIDTH'(RESET_ADDR);
        else          addr_q <= addr_d;
    end
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a queued scoreboard; covers both
// PC_STACK_EN builds.
module tb_program_sequencer;

    localparam int AW = 5;
    localparam int EW = AW + 3;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          up = 1'b0, jump = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [AW-1:0] target = '0, offset = '0;
    logic [AW-1:0] address;
    logic          stack_full, stack_empty, fault;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clock = ~clock;

    program_sequencer #(
        .ADDR_WIDTH  (AW),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .up          (up),
        .jump        (jump),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .offset      (offset),
        .address     (address),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault)
    );

    // Drive one command on the falling edge; the expected post-edge state is queued.
    task automatic step(input logic c_n, input logic u, input logic j, input logic b,
                        input logic c, input logic r, input logic [AW-1:0] tgt,
                        input logic [AW-1:0] off, input logic [AW-1:0] e_addr,
                        input logic e_full, input logic e_empty, input logic e_fault);
        @(negedge clock);
        clear_n = c_n; up = u; jump = j; branch = b; call = c; ret = r;
        target = tgt; offset = off;
        exp_q.push_back({e_addr, e_full, e_empty, e_fault});
    endtask

    // Shorthand for vectors where the stack is empty and no fault is expected.
    task automatic s(input logic u, input logic j, input logic b, input logic c,
                     input logic r, input logic [AW-1:0] tgt, input logic [AW-1:0] off,
                     input logic [AW-1:0] e_addr);
        step(1'b1, u, j, b, c, r, tgt, off, e_addr, 1'b0, 1'b1, 1'b0);
    endtask

    always @(posedge clock) begin
        logic [EW-1:0] e, got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {address, stack_full, stack_empty, fault};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL vec%0d {addr,full,empty,fault}: got addr=%0d f=%b e=%b flt=%b, expected addr=%0d f=%b e=%b flt=%b",
                         n_vec, got[EW-1:3], got[2], got[1], got[0], e[EW-1:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        int guard;
        // Reset, then 33 increments wrapping 31 -> 0.
        step(1'b0, 0, 0, 0, 0, 0, '0, '0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 33; i++) s(1, 0, 0, 0, 0, '0, '0, AW'(i % 32));

        // Branch both directions, including wrap and -1.
        s(0, 1, 0, 0, 0, 5'd10, '0, 5'd10);
        s(0, 0, 1, 0, 0, '0, 5'b11101, 5'd7);
        s(0, 0, 1, 0, 0, '0, 5'd4, 5'd11);
        s(0, 1, 0, 0, 0, 5'd30, '0, 5'd30);
        s(0, 0, 1, 0, 0, '0, 5'd5, 5'd3);
        s(0, 0, 1, 0, 0, '0, 5'b11111, 5'd2);

        // Jump beats everything; stack untouched.
        s(0, 1, 0, 0, 0, 5'd4, '0, 5'd4);
        s(1, 1, 1, 1, 1, 5'd20, 5'd1, 5'd20);
        s(0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd20);
        // Branch beats up.
        s(1, 0, 1, 0, 0, '0, 5'd2, 5'd22);
        // Reset overrides a concurrent jump.
        step(1'b0, 0, 1, 0, 0, 0, 5'd9, '0, 5'd0, 1'b0, 1'b1, 1'b0);

`ifdef PC_STACK_EN
        // Nested calls and returns.
        s(0, 1, 0, 0, 0, 5'd2, '0, 5'd2);
        step(1'b1, 0, 0, 0, 1, 0, 5'd8,  '0, 5'd8,  1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1, 0, 5'd16, '0, 5'd16, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 0, 1, '0,    '0, 5'd9,  1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 0, 1, '0,    '0, 5'd3,  1'b0, 1'b1, 1'b0);
        // Fill the stack (pushes 4, 11, 12, 13), then overflow.
        step(1'b1, 0, 0, 0, 1, 0, 5'd10, '0, 5'd10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1, 0, 5'd11, '0, 5'd11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1, 0, 5'd12, '0, 5'd12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1, 0, 5'd13, '0, 5'd13, 1'b1, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1, 0, 5'd20, '0, 5'd13, 1'b1, 1'b0, 1'b1);
        // Drain, then underflow; fault stays set but commands still work.
        step(1'b1, 0, 0, 0, 0, 1, '0, '0, 5'd13, 1'b0, 1'b0, 1'b1);
        step(1'b1, 0, 0, 0, 0, 1, '0, '0, 5'd12, 1'b0, 1'b0, 1'b1);
        step(1'b1, 0, 0, 0, 0, 1, '0, '0, 5'd11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 0, 0, 0, 0, 1, '0, '0, 5'd4,  1'b0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 0, 0, 1, '0, '0, 5'd4,  1'b0, 1'b1, 1'b1);
        step(1'b1, 1, 0, 0, 0, 0, '0, '0, 5'd5,  1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 0, 0, '0, '0, 5'd0,  1'b0, 1'b1, 1'b0);
        // Call then immediate return; call beats ret; ret beats branch/up.
        step(1'b1, 0, 0, 0, 1, 0, 5'd5, '0, 5'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 0, 1, '0,   '0, 5'd1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1, 1, 5'd7, '0, 5'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 1, 0, 1, '0, 5'd3, 5'd2, 1'b0, 1'b1, 1'b0);
`else
        // Without the stack: call acts as jump, ret holds, no fault ever.
        s(0, 0, 0, 1, 0, 5'd12, '0, 5'd12);
        s(0, 0, 0, 0, 1, '0, '0, 5'd12);
        s(0, 0, 0, 0, 1, '0, '0, 5'd12);
        s(1, 0, 1, 1, 1, 5'd7, 5'd9, 5'd7);
        s(1, 0, 1, 0, 1, 5'd1, 5'd3, 5'd7);
        s(1, 0, 1, 0, 0, '0, 5'd2, 5'd9);
        s(1, 0, 0, 0, 0, '0, '0, 5'd10);
        s(0, 0, 0, 0, 0, '0, '0, 5'd10);
`endif

        @(negedge clock);
        clear_n = 1'b1; up = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
